// File: rtl/alu_pkg.sv
// alu_pkg: shared RV32I ALU constants (funct3/funct7 encodings, datapath widths)
package alu_pkg;
    localparam int XLEN = 32;
    localparam int SHW  = 5;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one right-shift mux level of distance D with a fill bit
//   d_i    : data in
//   fill_i : bit shifted into the vacated upper positions
//   en_i   : 1 = shift by D, 0 = pass through
//   q_o    : data out
module shift_stage
    import alu_pkg::*;
#(
    parameter int D = 1
) (
    input  logic [XLEN-1:0] d_i,
    input  logic            fill_i,
    input  logic            en_i,
    output logic [XLEN-1:0] q_o
);
    assign q_o = en_i ? {{D{fill_i}}, d_i[XLEN-1:D]} : d_i;
endmodule

// File: rtl/barrel_shifter32.sv
// barrel_shifter32: RV32I SLL/SRL/SRA shifter with combinational and registered outputs
//   clk, rst_n : clock and async active-low reset (register stage only)
//   i, s       : operand and 5-bit shift amount
//   func3      : 1 = left, 0 = right;  func7 : 1 = arithmetic (right only)
//   in_valid   : qualifies inputs for the register stage
//   o          : combinational result;  o_q / o_valid : registered result and flag
module barrel_shifter32
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i,
    input  logic [SHW-1:0]  s,
    input  logic            func3,
    input  logic            func7,
    input  logic            in_valid,
    output logic [XLEN-1:0] o,
    output logic [XLEN-1:0] o_q,
    output logic            o_valid
);
    function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int k = 0; k < XLEN; k++) r[k] = v[XLEN-1-k];
        return r;
    endfunction

    logic [SHW:0][XLEN-1:0] st;
    logic                   fill;
    logic [XLEN-1:0]        o_d;

    // left shifts run through the right-shift network on a bit-reversed operand
    assign fill  = func7 & ~func3 & i[XLEN-1];
    assign st[0] = func3 ? rev(i) : i;

    genvar k;
    for (k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(.D(1 << (SHW-1-k))) u_stage (
            .d_i    (st[k]),
            .fill_i (fill),
            .en_i   (s[SHW-1-k]),
            .q_o    (st[k+1])
        );
    end

    assign o   = func3 ? rev(st[SHW]) : st[SHW];
    assign o_d = in_valid ? o : o_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_q     <= o_d;
            o_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_barrel_shifter32.sv
// tb_barrel_shifter32: scoreboard bench with directed and random shift vectors
module tb_barrel_shifter32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i = '0;
    logic [4:0]  s = '0;
    logic        func3 = 1'b0;
    logic        func7 = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] o;
    logic [31:0] o_q;
    logic        o_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    barrel_shifter32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i        (i),
        .s        (s),
        .func3    (func3),
        .func7    (func7),
        .in_valid (in_valid),
        .o        (o),
        .o_q      (o_q),
        .o_valid  (o_valid)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh,
                                          input logic f3, input logic f7);
        logic signed [31:0] t;
        t = a;
        if (f3) return a << sh;
        if (f7) return t >>> sh;
        return a >> sh;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] sh, input logic f3,
                         input logic f7, input logic [31:0] e, input string name);
        @(negedge clk);
        i = a;
        s = sh;
        func3 = f3;
        func7 = f7;
        in_valid = 1'b1;
        #1;
        chk(name, o, e);
        if (rst_n) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow got o_q %h want no output", o_q);
            end else begin
                chk("sb_o_q", o_q, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  sh;
        logic        f3, f7;
        #3;
        chk("rst_o_q", o_q, 32'h0);
        chk("rst_o_valid", {31'b0, o_valid}, 32'h0);
        drive(32'h00000001, 5'd4, 1'b1, 1'b0, 32'h00000010, "rst_o_tracks");
        @(posedge clk);
        #1;
        chk("rst_hold_o_q", o_q, 32'h0);
        chk("rst_hold_o_valid", {31'b0, o_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        drive(32'h00000001, 5'd4,  1'b1, 1'b0, 32'h00000010, "sll");
        drive(32'hF0000000, 5'd4,  1'b0, 1'b0, 32'h0F000000, "srl");
        drive(32'hF0000000, 5'd4,  1'b0, 1'b1, 32'hFF000000, "sra_neg");
        drive(32'h70000000, 5'd4,  1'b0, 1'b1, 32'h07000000, "sra_pos");
        drive(32'hDEADBEEF, 5'd0,  1'b1, 1'b0, 32'hDEADBEEF, "s0_sll");
        drive(32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'hDEADBEEF, "s0_srl");
        drive(32'hDEADBEEF, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF, "s0_sra");
        drive(32'hDEADBEEF, 5'd0,  1'b1, 1'b1, 32'hDEADBEEF, "s0_sll_f7");
        drive(32'h80000001, 5'd31, 1'b1, 1'b0, 32'h80000000, "s31_sll");
        drive(32'h80000001, 5'd31, 1'b0, 1'b0, 32'h00000001, "s31_srl");
        drive(32'h80000001, 5'd31, 1'b0, 1'b1, 32'hFFFFFFFF, "s31_sra");
        drive(32'h80000001, 5'd31, 1'b1, 1'b1, 32'h80000000, "s31_sll_f7");
        drive(32'h00000001, 5'd4,  1'b1, 1'b1, 32'h00000010, "sll_f7");

        @(negedge clk);
        in_valid = 1'b0;
        i = 32'h12345678;
        s = 5'd3;
        func3 = 1'b1;
        func7 = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_o_q", o_q, 32'h00000010);
        chk("hold_o_valid", {31'b0, o_valid}, 32'h0);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_o_q", o_q, 32'h0);
        chk("async_o_valid", {31'b0, o_valid}, 32'h0);
        chk("async_o_tracks", o, model(32'h12345678, 5'd3, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00000001, 5'd4, 1'b1, 1'b0, 32'h00000010, "post_rst_sll");

        repeat (10000) begin
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            f3 = 1'($urandom_range(0, 1));
            f7 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            drive(a, sh, f3, f7, model(a, sh, f3, f7), "rand_o");
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrel_shifter32.md
# barrel_shifter32

32-bit barrel shifter for the RV32I execute stage, implementing SLL, SRL and SRA for both register (SLL/SRL/SRA) and immediate (SLLI/SRLI/SRAI) forms. The ALU decoder reduces funct3/funct7 to two mode flags before they reach this block. Every shift result is available combinationally on `o` in the same cycle. A registered copy with a valid flag is also provided for pipelined datapaths.

## Interface
Parameters:
- None. Width is fixed at 32; shift amount is fixed at 5 bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock, used only by the output register stage
- `rst_n`  in  1  asynchronous active-low reset
- `i`  in  32  operand to shift (rs1)
- `s`  in  5  shift amount (rs2[4:0] or shamt); upper rs2 bits are discarded upstream
- `func3`  in  1  direction flag: 1 = shift left (funct3 == 3'b001), 0 = shift right
- `func7`  in  1  arithmetic flag: 1 = arithmetic (funct7 == 7'b0100000), 0 = logical
- `in_valid`  in  1  qualifies `i`/`s`/`func3`/`func7` for the register stage
- `o`  out  32  combinational shift result
- `o_q`  out  32  registered result, one cycle after `in_valid`
- `o_valid`  out  1  registered copy of `in_valid`

## Operation
Mode decode from `{func3, func7}`:
- `1x` → SLL: `o = i << s`, zero fill.
- `00` → SRL: `o = i >> s`, zero fill.
- `01` → SRA: `o = i >>> s`, fill with `i[31]`.
- When `func3 = 1`, `func7` is ignored. There is no arithmetic left shift.

Shift network:
- Five cascaded mux stages of 16, 8, 4, 2 and 1 bit positions, enabled by `s[4]`..`s[0]`.
- Left shifts reuse the right-shift network: bit-reverse `i` on entry, force the fill bit to 0, and bit-reverse the result on exit.
- Fill bit = `func7 & ~func3 & i[31]`.

Boundary conditions:
- `s = 0` → `o = i` in every mode.
- `s = 31` in SLL → `{i[0], 31'b0}`.
- `s = 31` in SRL → `{31'b0, i[31]}`.
- `s = 31` in SRA → all bits equal `i[31]`.

X handling: no `x` may propagate from unselected mux legs when the selected inputs are known.

## Timing
- `o` is purely combinational, with zero-cycle latency from any input change. It contains no latch and no clock dependency.
- Register stage:
  - On each rising `clk`, `o_q <= o` when `in_valid = 1`; otherwise `o_q` holds its value.
  - `o_valid <= in_valid` on every rising `clk`.
- Reset: while `rst_n = 0`, `o_q = 32'h0` and `o_valid = 0`, asynchronously and regardless of `clk`. `o` continues to track the inputs during reset.
- Reset release mid-stream: the first capture occurs on the first rising edge that has `rst_n = 1` and `in_valid = 1`.
- Back-to-back `in_valid` pulses produce one result per cycle. There is no back-pressure.

## Structure
- Shared package `alu_pkg` holds:
  - funct3 constants `F3_SLL = 3'b001`, `F3_SR = 3'b101`
  - funct7 constants `F7_BASE = 7'b0000000`, `F7_ALT = 7'b0100000`
- One sub-module, `shift_stage`, parameterised by shift distance. It takes data and fill bit and produces one mux level. It is instantiated five times.
- The bit-reversal helper is a function local to the top module.

## Test plan
- SLL: `i = 32'h00000001`, `s = 4`, `func3 = 1`, `func7 = 0` → `o = 32'h00000010`.
- SRL: `i = 32'hF0000000`, `s = 4`, `func3 = 0`, `func7 = 0` → `o = 32'h0F000000`.
- SRA: `i = 32'hF0000000`, `s = 4`, `func3 = 0`, `func7 = 1` → `o = 32'hFF000000`.
- SRA with a positive operand: `i = 32'h70000000`, `s = 4` → `32'h07000000`.
- Extremes:
  - `s = 0` with `i = 32'hDEADBEEF` returns the input in all modes.
  - `s = 31` with `i = 32'h80000001`: SLL → `32'h80000000`, SRL → `32'h00000001`, SRA → `32'hFFFFFFFF`.
  - Setting `func3 = 1` with `func7 = 1` still performs a plain SLL.
- Register stage:
  - Hold `rst_n = 0` and check `o_q = 0` and `o_valid = 0`.
  - Release reset and pulse `in_valid` with the SLL vector above. One edge later `o_q = 32'h00000010` and `o_valid = 1`.
  - Drop `in_valid` and check that `o_q` holds.
  - Assert `rst_n = 0` between clock edges and check `o_q` clears immediately.
- Random: 10k random `i`/`s`/mode vectors compared against a behavioural `<<`, `>>`, `>>>` model.
